// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: arbiter states, byte type and
// the largest requester count the arbiter is built for.
package uart_pkg;

  localparam int UART_ARB_MAX_REQ = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request searching
// upward from last_grant+1 with wrap, as a one-hot vector and an index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic found;

  // Offsets 1..N from the previous winner give the rotating priority order.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    any_req   = |req;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last_grant) + k) % N]) begin
        found                                = 1'b1;
        grant_oh[(int'(last_grant) + k) % N] = 1'b1;
        grant_idx                            = IW'((int'(last_grant) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx between N_REQ byte
// streams, with a stall timeout that revokes a grant from a dead requester.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*8-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_req,
  output byte_t                    tx_data,
  input  logic                     tx_rdy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int GW    = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  arb_state_t        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic [GW-1:0]     last_q, last_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [GW-1:0]     pick_idx;
  logic              any_req;

  logic              g_valid;
  logic              g_last;
  byte_t             g_data;
  logic              transfer;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (GW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any_req    (any_req)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*8 +: 8];
      end
    end
  end

  // A byte already on the wire outranks the timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    last_d      = last_q;
    stall_d     = stall_q;
    tx_req      = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    transfer    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          state_d    = SEND;
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          stall_d    = '0;
        end
      end
      SEND: begin
        busy      = 1'b1;
        transfer  = g_valid & tx_rdy;
        tx_req    = transfer;
        tx_data   = g_data;
        req_ready = grant_oh_q & {N_REQ{tx_rdy}};
        if (transfer) begin
          stall_d = '0;
          if (g_last) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end else if (TIMEOUT_EN && (stall_q >= CNT_LIMIT)) begin
          timeout_err = 1'b1;
          last_d      = grant_q;
          state_d     = IDLE;
        end else if (tx_rdy && (stall_q != '1)) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= N_REQ'(1);
      last_q     <= GW'(N_REQ - 1);
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      last_q     <= last_d;
      stall_q    <= stall_d;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter: a packet-level reference
// model predicts every cycle's outputs and every transmitted byte.
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int TO = 16;

  logic          clk;
  logic          nrst;
  logic          enable;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_req;
  logic [7:0]    tx_data;
  logic          tx_rdy;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  uart_tx_arbiter #(
    .N_REQ   (NR),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit         chk;
    logic       busy;
    logic [2:0] ready;
    logic       tx_req;
    logic       to;
    logic [7:0] data;
    logic [1:0] grant;
  } cyc_t;

  cyc_t       exp_cyc[$];
  logic [9:0] exp_byte[$];
  logic [8:0] rq[NR][$];
  logic [7:0] obs_data[$];
  logic [1:0] obs_grant[$];

  int n_vec = 0;
  int n_mis = 0;

  int stall_pct, frame_min, frame_max, uart_busy;
  logic nrst_tb, enable_tb;
  bit model_known;
  int m_owner, m_last, m_stall, m_grant;

  bit to_phase, to_armed;
  int to_cnt, to_at, to_pulses;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic loadPacket(int r, logic [7:0] b0, int len, bit with_last);
    for (int k = 0; k < len; k++)
      rq[r].push_back({(with_last && k == len - 1), 8'(b0 + k)});
  endtask

  task automatic clearLog();
    obs_data.delete();
    obs_grant.delete();
  endtask

  task automatic checkLog(string name, int idx, logic [1:0] eg, logic [7:0] ed);
    checkOutput({name, "_data"}, (idx < obs_data.size()) ? 32'(obs_data[idx]) : 32'hFFFF_FFFF, 32'(ed));
    checkOutput({name, "_grant"}, (idx < obs_grant.size()) ? 32'(obs_grant[idx]) : 32'hFFFF_FFFF, 32'(eg));
  endtask

  // One clock of stimulus: drive inputs, predict outputs from the model,
  // then advance requesters, the uart_tx stand-in and the model.
  task automatic applyStimulus();
    logic [NR-1:0]   v;
    logic [NR-1:0]   l;
    logic [NR*8-1:0] d;
    logic            rdy;
    logic            xfer;
    cyc_t            e;
    int              g;
    v = '0; l = '0; d = '0; xfer = 1'b0; g = 0;
    rdy = (uart_busy == 0);
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        d[i*8 +: 8] = rq[i][0][7:0];
        l[i]        = rq[i][0][8];
        v[i]        = ($urandom_range(0, 99) >= stall_pct);
      end
    end
    req_valid = v; req_last = l; req_data = d; tx_rdy = rdy;
    enable = enable_tb; nrst = nrst_tb;

    e = '0;
    e.chk   = model_known;
    e.busy  = (m_owner >= 0);
    e.grant = 2'(m_grant);
    if (m_owner >= 0) begin
      g        = m_owner;
      xfer     = v[g] & rdy;
      e.tx_req = xfer;
      e.ready[g] = rdy;
      e.data   = d[g*8 +: 8];
      e.to     = !xfer && (m_stall >= TO);
    end
    exp_cyc.push_back(e);
    if (model_known && xfer) exp_byte.push_back({2'(g), d[g*8 +: 8]});

    if (xfer) void'(rq[g].pop_front());
    if (xfer) uart_busy = $urandom_range(frame_max, frame_min);
    else if (uart_busy > 0) uart_busy--;

    if (!nrst_tb) begin
      m_owner = -1; m_last = NR - 1; m_stall = 0; m_grant = 0;
      model_known = 1'b1;
      uart_busy = 0;
    end else if (m_owner < 0) begin
      if (enable_tb && (v != '0)) begin
        for (int k = 1; k <= NR; k++) begin
          if (m_owner < 0 && v[(m_last + k) % NR]) begin
            m_owner = (m_last + k) % NR;
            m_grant = m_owner;
            m_stall = 0;
          end
        end
      end
    end else begin
      if (xfer) begin
        m_stall = 0;
        if (l[g]) begin m_last = g; m_owner = -1; end
      end else if (e.to) begin
        m_last = g; m_owner = -1;
      end else if (rdy && !v[g]) begin
        m_stall++;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic runUntilIdle(int max_cycles);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() > 0 || m_owner >= 0 || uart_busy > 0)
           && n < max_cycles) begin
      applyStimulus();
      n++;
    end
    if (n >= max_cycles) begin
      n_vec++;
      n_mis++;
      $display("[TB] FAIL drain_bound: still active after %0d cycles, expected idle", n);
    end
    applyStimulus();
  endtask

  // Monitor: pops one prediction per cycle and one byte per tx_req.
  always @(negedge clk) begin
    cyc_t       e;
    logic [9:0] b;
    if (exp_cyc.size() > 0) begin
      e = exp_cyc.pop_front();
      if (e.chk) begin
        checkOutput("busy", 32'(busy), 32'(e.busy));
        checkOutput("req_ready", 32'(req_ready), 32'(e.ready));
        checkOutput("tx_req", 32'(tx_req), 32'(e.tx_req));
        checkOutput("timeout_err", 32'(timeout_err), 32'(e.to));
        checkOutput("tx_data", 32'(tx_data), 32'(e.data));
        checkOutput("grant_id", 32'(grant_id), 32'(e.grant));
      end
      if (tx_req === 1'b1) begin
        obs_data.push_back(tx_data);
        obs_grant.push_back(grant_id);
        if (exp_byte.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("[TB] FAIL sb_byte: got unexpected byte %0h, expected none", tx_data);
        end else begin
          b = exp_byte.pop_front();
          checkOutput("sb_data", 32'(tx_data), 32'(b[7:0]));
          checkOutput("sb_grant", 32'(grant_id), 32'(b[9:8]));
        end
      end
      if (to_phase) begin
        if (timeout_err === 1'b1) begin
          to_pulses++;
          if (to_armed) to_at = to_cnt;
          to_armed = 1'b0;
        end else if (to_armed && tx_rdy && !req_valid[0]) begin
          to_cnt++;
        end
        if (tx_req === 1'b1 && tx_data === 8'h77) begin
          to_armed = 1'b1;
          to_cnt   = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nrst_tb = 1'b0; enable_tb = 1'b1; stall_pct = 0;
    frame_min = 2; frame_max = 4; uart_busy = 0;
    model_known = 1'b0; m_owner = -1; m_last = NR - 1; m_stall = 0; m_grant = 0;
    to_phase = 1'b0; to_armed = 1'b0; to_cnt = 0; to_at = -1; to_pulses = 0;
    nrst = 1'b0; enable = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_rdy = 1'b1;
    @(posedge clk);
    #1;

    repeat (3) applyStimulus();
    nrst_tb = 1'b1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_tx_req", 32'(tx_req), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_grant_id", 32'(grant_id), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);

    clearLog();
    loadPacket(0, 8'h41, 1, 1'b1);
    loadPacket(1, 8'h42, 1, 1'b1);
    runUntilIdle(200);
    checkOutput("prio_count", obs_data.size(), 2);
    checkLog("prio0", 0, 2'd0, 8'h41);
    checkLog("prio1", 1, 2'd1, 8'h42);

    clearLog();
    loadPacket(0, 8'h10, 3, 1'b1);
    loadPacket(1, 8'h55, 1, 1'b1);
    runUntilIdle(200);
    checkOutput("lock_count", obs_data.size(), 4);
    checkLog("lock0", 0, 2'd0, 8'h10);
    checkLog("lock1", 1, 2'd0, 8'h11);
    checkLog("lock2", 2, 2'd0, 8'h12);
    checkLog("lock3", 3, 2'd1, 8'h55);

    clearLog();
    for (int k = 0; k < 3; k++) begin
      loadPacket(0, 8'(8'h20 + k), 1, 1'b1);
      loadPacket(1, 8'(8'h30 + k), 1, 1'b1);
    end
    runUntilIdle(300);
    checkOutput("fair_count", obs_data.size(), 6);
    for (int k = 0; k < 6; k++)
      checkLog("fair", k, 2'(k % 2), (k % 2 == 0) ? 8'(8'h20 + k / 2) : 8'(8'h30 + k / 2));

    clearLog();
    to_phase = 1'b1; to_pulses = 0; to_at = -1;
    loadPacket(0, 8'h77, 1, 1'b0);
    loadPacket(1, 8'h88, 1, 1'b1);
    runUntilIdle(300);
    to_phase = 1'b0;
    checkOutput("to_pulses", to_pulses, 1);
    checkOutput("to_idle_cycles", to_at, TO);
    checkLog("to0", 0, 2'd0, 8'h77);
    checkLog("to1", 1, 2'd1, 8'h88);

    clearLog();
    enable_tb = 1'b0;
    loadPacket(0, 8'h5A, 1, 1'b1);
    repeat (50) applyStimulus();
    checkOutput("en_low_busy", 32'(busy), 0);
    checkOutput("en_low_count", obs_data.size(), 0);
    enable_tb = 1'b1;
    applyStimulus();
    checkOutput("en_high_busy", 32'(busy), 1);
    checkOutput("en_high_grant", 32'(grant_id), 0);
    runUntilIdle(200);

    clearLog();
    frame_min = 3; frame_max = 3;
    loadPacket(0, 8'h01, 4, 1'b1);
    for (int n = 0; n < 100 && obs_data.size() < 2; n++) applyStimulus();
    checkOutput("mid_busy", 32'(busy), 1);
    nrst_tb = 1'b0;
    applyStimulus();
    checkOutput("mrst_busy", 32'(busy), 0);
    checkOutput("mrst_tx_req", 32'(tx_req), 0);
    checkOutput("mrst_req_ready", 32'(req_ready), 0);
    for (int r = 0; r < NR; r++) rq[r].delete();
    nrst_tb = 1'b1;
    repeat (3) applyStimulus();

    stall_pct = 20; frame_min = 1; frame_max = 4;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NR; r++)
        if (rq[r].size() == 0 && $urandom_range(0, 9) == 0)
          loadPacket(r, 8'($urandom), $urandom_range(1, 4), ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 19) == 0) enable_tb = !enable_tb;
      applyStimulus();
    end
    enable_tb = 1'b1;
    runUntilIdle(2000);

    repeat (2) applyStimulus();
    @(negedge clk);
    #1;
    checkOutput("sb_leftover", exp_byte.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` byte transmitter between `N_REQ` byte-stream requesters, such as the JPEG bitstream packer and the debug/status message source. Packets are granted whole: a requester keeps the transmitter from its first byte until a byte carrying `req_last`. Arbitration between packets is round-robin. A per-packet stall timeout stops a dead requester from holding the UART forever. The block sits between the requesters and `uart_tx`, driving its `tx_req`/`tx_data` and observing `tx_rdy`.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 1024: stall cycles, counted while the granted requester is idle and the UART is ready, before the grant is revoked. 0 disables the timeout.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset; one clock, synchronous, active-low.
- `enable`  in  1  when low, no new packet is granted; a packet in progress completes.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  N_REQ*8  requester i's byte is in bits [8i+7:8i].
- `req_last`  in  N_REQ  byte is the last of its packet.
- `req_ready`  out  N_REQ  byte accepted (one-hot or zero).
- `tx_req`  out  1  to `uart_tx`.
- `tx_data`  out  8  to `uart_tx`.
- `tx_rdy`  in  1  from `uart_tx`; high while its FSM is idle.
- `grant_id`  out  $clog2(N_REQ)  current/last granted requester.
- `busy`  out  1  a packet is in progress.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- State machine `arb_state_t`: IDLE, SEND.
- **IDLE**
  - If `enable` and any `req_valid`, pick the first valid requester searching from `(last_grant+1) mod N_REQ` upward with wrap.
  - Register the pick as `grant_id` and go to SEND.
  - No bytes are accepted in IDLE.
- **SEND, outputs (combinational)**
  - `g = grant_id`.
  - `tx_data = req_data[g]`.
  - `tx_req = req_valid[g] & tx_rdy`.
  - `req_ready[g] = tx_rdy`; all other bits of `req_ready` are 0.
- **SEND, transfer**
  - A transfer is a cycle with `req_valid[g] & tx_rdy`.
  - If `req_last[g]` on a transfer: `last_grant <= g`, go to IDLE.
  - Otherwise stay in SEND.
- **Stall counter**
  - Cleared on entry to SEND and on every transfer.
  - Increments while SEND, `tx_rdy` is high and `req_valid[g]` is low.
  - Holds while `tx_rdy` is low, i.e. while the UART is sending a frame.
  - Width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.
- **Timeout**
  - When the counter reaches `TIMEOUT` (and `TIMEOUT` ≠ 0): pulse `timeout_err`, set `last_grant <= g`, go to IDLE.
  - The partial packet is abandoned, not flushed.
- `busy = (state == SEND)`.
- `enable` low has no effect in SEND.

## Timing
- **Reset values:** state IDLE, `grant_id` 0, `last_grant` N_REQ-1 (requester 0 has first priority), counter 0. All outputs 0: `tx_req`, `req_ready`, `busy`, `timeout_err`, `tx_data`.
- **Grant latency:** `req_valid` seen in IDLE at cycle t → SEND at t+1. `tx_req`/`req_ready` can be high at t+1 if `tx_rdy` is high. The minimum gap between packets is one IDLE cycle.
- **Handshake:** a byte is consumed exactly on a cycle with `req_valid[g] & req_ready[g]`. `uart_tx` drops `tx_rdy` the cycle after `tx_req`, so at most one byte is accepted per frame.
- **Simultaneous events:**
  - A transfer and the timeout threshold in the same cycle: the transfer wins and there is no error.
  - Several requesters valid in IDLE: exactly one grant, per the round-robin order.
- **Reset mid-packet:** returns to IDLE next edge and drops all outputs. The packet is lost; no recovery is attempted.
- **Requester changes:** a requester may deassert `req_valid` mid-packet (a stall). Changing `req_data` while valid and not ready is a protocol violation and is not checked.

## Structure
- **Shared package `uart_pkg`:**
  - `arb_state_t` enum.
  - `byte_t` (`logic [7:0]`).
  - Constant `UART_ARB_MAX_REQ = 8`.
- **Sub-module `rr_arbiter`:** combinational.
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot pick, its index, and an any-request flag.
  - Reusable for the other shared resources.
- The top level holds the FSM, the registers, the stall counter and the output muxing.

## Test plan
- **Reset priority:** reset, both requesters valid with 1-byte packets (0x41 on req0, 0x42 on req1), `tx_rdy` modelled per `uart_tx` → bytes sent 0x41 then 0x42. `grant_id` 0 then 1. One IDLE cycle between the packets.
- **Packet lock:** req0 sends a 3-byte packet 0x10,0x11,0x12 (last on 0x12) while req1 is held valid throughout → `tx_data` sequence 0x10,0x11,0x12,then req1's byte. req1's `req_ready` stays 0 until req0's last byte.
- **Fairness:** both requesters continuously valid with 1-byte packets, 6 packets → strict alternation 0,1,0,1,0,1.
- **Timeout:** `TIMEOUT` = 16; req0 sends one non-last byte, then `req_valid` stays low with `tx_rdy` high → `timeout_err` pulses once, 16 ready-idle cycles after the UART frame ends. The next grant goes to req1 if valid.
- **Enable and reset:** `enable` low with req0 valid → no grant for 50 cycles. Raise `enable` → grant next cycle. Assert `nrst` mid-packet → next edge `busy`=0, `tx_req`=0, `req_ready`=0.
